rtc_bus_ctrl: RTL and testbench

//  Responder side of the RTC handshake: accepts one read/write command (start, rw, addr, wdata)

---
 rtl/rtc_bus_ctrl_pkg.sv | 29 ++
 rtl/rtc_bus_ctrl_phase_timer.sv | 35 +++
 rtl/rtc_bus_ctrl.sv | 140 ++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC bus controller: state encodings, command
// direction codes, default bus timing and the zero-means-one timing rule.
package rtc_bus_ctrl_pkg;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_A_SU = 4'd1;
  localparam logic [3:0] S_A_PW = 4'd2;
  localparam logic [3:0] S_A_HD = 4'd3;
  localparam logic [3:0] S_D_SU = 4'd4;
  localparam logic [3:0] S_D_PW = 4'd5;
  localparam logic [3:0] S_D_HD = 4'd6;
  localparam logic [3:0] S_DONE = 4'd7;
  localparam logic [3:0] S_GAP  = 4'd8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DEF_T_SU  = 2;
  localparam int DEF_T_PW  = 4;
  localparam int DEF_T_HD  = 2;
  localparam int DEF_T_GAP = 4;
  localparam int DEF_CNT_W = 4;

  // A programmed duration of zero still occupies one cycle.
  function automatic int eff_cycles(input int t);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Phase down-counter for the RTC bus controller: reloaded on each state entry,
// flags the last cycle of the current phase.
module rtc_bus_ctrl_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC bus controller: runs one read/write command on the RTC multiplexed
// address/data bus. Optional post-transaction recovery gap: RTC_BUS_GAP_EN.
module rtc_bus_ctrl
  import rtc_bus_ctrl_pkg::*;
#(
  parameter int T_SU  = DEF_T_SU,
  parameter int T_PW  = DEF_T_PW,
  parameter int T_HD  = DEF_T_HD,
  parameter int T_GAP = DEF_T_GAP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       rd_valid_o,
  output logic [7:0] rdata_o,
  output logic       rtc_cs_n_o,
  output logic       rtc_rd_n_o,
  output logic       rtc_wr_n_o,
  output logic       rtc_ad_sel_o,
  inout  wire  [7:0] rtc_ad_io
);

`ifdef RTC_BUS_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] SU_LD  = CNT_W'(eff_cycles(T_SU) - 1);
  localparam logic [CNT_W-1:0] PW_LD  = CNT_W'(eff_cycles(T_PW) - 1);
  localparam logic [CNT_W-1:0] HD_LD  = CNT_W'(eff_cycles(T_HD) - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(eff_cycles(T_GAP) - 1);

  logic [3:0]       state_q, state_d;
  logic             rw_q, rw_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d, ad_dat_q, ad_dat_d;
  logic             busy_q, busy_d, rd_valid_q, rd_valid_d;
  logic             cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic             ad_sel_q, ad_sel_d, ad_oe_q, ad_oe_d;
  logic             tmr_load, tmr_zero, accept, in_a, in_d;
  logic [CNT_W-1:0] tmr_val;

  rtc_bus_ctrl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (1'b1),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: if (start_i)  begin state_d = S_A_SU; tmr_load = 1'b1; tmr_val = SU_LD; end
      S_A_SU: if (tmr_zero) begin state_d = S_A_PW; tmr_load = 1'b1; tmr_val = PW_LD; end
      S_A_PW: if (tmr_zero) begin state_d = S_A_HD; tmr_load = 1'b1; tmr_val = HD_LD; end
      S_A_HD: if (tmr_zero) begin state_d = S_D_SU; tmr_load = 1'b1; tmr_val = SU_LD; end
      S_D_SU: if (tmr_zero) begin state_d = S_D_PW; tmr_load = 1'b1; tmr_val = PW_LD; end
      S_D_PW: if (tmr_zero) begin state_d = S_D_HD; tmr_load = 1'b1; tmr_val = HD_LD; end
      S_D_HD: if (tmr_zero) begin state_d = S_DONE; end
      S_DONE: begin
        if (GAP_EN) begin state_d = S_GAP; tmr_load = 1'b1; tmr_val = GAP_LD; end
        else        begin state_d = S_IDLE; end
      end
      S_GAP:  if (tmr_zero) begin state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values are computed from the next state so every pin comes straight off a flop.
  always_comb begin
    accept     = (state_q == S_IDLE) && start_i;
    rw_d       = accept ? rw_i    : rw_q;
    addr_d     = accept ? addr_i  : addr_q;
    wdata_d    = accept ? wdata_i : wdata_q;
    in_a       = (state_d == S_A_SU) || (state_d == S_A_PW) || (state_d == S_A_HD);
    in_d       = (state_d == S_D_SU) || (state_d == S_D_PW) || (state_d == S_D_HD);
    busy_d     = (state_d != S_IDLE);
    rd_valid_d = (state_d == S_DONE) && (rw_d == RW_READ);
    cs_n_d     = !(in_a || in_d);
    ad_sel_d   = in_d;
    wr_n_d     = !((state_d == S_A_PW) || ((state_d == S_D_PW) && (rw_d == RW_WRITE)));
    rd_n_d     = !((state_d == S_D_PW) && (rw_d == RW_READ));
    ad_oe_d    = in_a || (in_d && (rw_d == RW_WRITE));
    ad_dat_d   = in_d ? wdata_d : addr_d;
    // Capture while rd_n is still low, on the edge that ends the strobe.
    rdata_d    = ((state_q == S_D_PW) && tmr_zero && (rw_q == RW_READ)) ? rtc_ad_io : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rw_q       <= RW_READ;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      ad_dat_q   <= 8'h00;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_sel_q   <= 1'b0;
      ad_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ad_dat_q   <= ad_dat_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      ad_sel_q   <= ad_sel_d;
      ad_oe_q    <= ad_oe_d;
    end
  end

  assign rtc_ad_io    = ad_oe_q ? ad_dat_q : 8'hzz;
  assign busy_o       = busy_q;
  assign rd_valid_o   = rd_valid_q;
  assign rdata_o      = rdata_q;
  assign rtc_cs_n_o   = cs_n_q;
  assign rtc_rd_n_o   = rd_n_q;
  assign rtc_wr_n_o   = wr_n_q;
  assign rtc_ad_sel_o = ad_sel_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: default timing instance plus a short-timing
// instance (T_SU=1, T_PW=1, T_HD=0), each with a simple RTC read-data model.
module tb_rtc_bus_ctrl;

`ifdef RTC_BUS_GAP_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  typedef struct {
    logic       sel;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] model;
    logic [7:0] exp_rdata;
    int         exp_busy;
    int         exp_rdv_idx;
    int         exp_pw;
  } vec_t;

  int tests  = 0;
  int failed = 0;

  logic       clk = 1'b0;
  logic       reset, start_a, start_b, rw, sel;
  logic [7:0] addr, wdata, model_byte;

  logic       busy_a, rdv_a, cs_n_a, rd_n_a, wr_n_a, sel_a;
  logic       busy_b, rdv_b, cs_n_b, rd_n_b, wr_n_b, sel_b;
  logic [7:0] rdata_a, rdata_b;
  wire  [7:0] bus_a, bus_b;

  always #5 clk = ~clk;

  // RTC model drives read data only while the read strobe is low.
  assign bus_a = rd_n_a ? 8'hzz : model_byte;
  assign bus_b = rd_n_b ? 8'hzz : model_byte;

  rtc_bus_ctrl dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy_a), .rd_valid_o(rdv_a), .rdata_o(rdata_a), .rtc_cs_n_o(cs_n_a),
    .rtc_rd_n_o(rd_n_a), .rtc_wr_n_o(wr_n_a), .rtc_ad_sel_o(sel_a), .rtc_ad_io(bus_a)
  );

  rtc_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(0)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .rw_i(rw), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy_b), .rd_valid_o(rdv_b), .rdata_o(rdata_b), .rtc_cs_n_o(cs_n_b),
    .rtc_rd_n_o(rd_n_b), .rtc_wr_n_o(wr_n_b), .rtc_ad_sel_o(sel_b), .rtc_ad_io(bus_b)
  );

  wire       busy_m = sel ? busy_b  : busy_a;
  wire       rdv_m  = sel ? rdv_b   : rdv_a;
  wire       cs_n_m = sel ? cs_n_b  : cs_n_a;
  wire       rd_n_m = sel ? rd_n_b  : rd_n_a;
  wire       wr_n_m = sel ? wr_n_b  : wr_n_a;
  wire       asel_m = sel ? sel_b   : sel_a;
  wire [7:0] rdat_m = sel ? rdata_b : rdata_a;
  wire [7:0] bus_m  = sel ? bus_b   : bus_a;
  wire       oe_m   = sel ? dut_b.ad_oe_q : dut_a.ad_oe_q;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, busy_cnt = 0, wr_a = 0, wr_d = 0, rd_lo = 0, rdv_cnt = 0, rdv_idx = -1, viol = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    sel = v.sel; rw = v.rw; addr = v.addr; wdata = v.wdata; model_byte = v.model;
    if (v.sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (!busy_m) done = 1'b1;
      else begin
        busy_cnt++;
        if (!wr_n_m && !asel_m && bus_m == v.addr)  wr_a++;
        if (!wr_n_m &&  asel_m && bus_m == v.wdata) wr_d++;
        if (!rd_n_m &&  asel_m && bus_m == v.model) rd_lo++;
        if (rdv_m) begin rdv_cnt++; rdv_idx = cyc; end
        if (!rd_n_m && !wr_n_m) viol++;
        if ((!rd_n_m || !wr_n_m) && cs_n_m) viol++;
        if (!cs_n_m && !asel_m && !oe_m) viol++;
        if (!cs_n_m && asel_m && (oe_m != v.rw)) viol++;
        if (cs_n_m && oe_m) viol++;
        cyc++;
      end
    end
    chk($sformatf("v%0d_timeout", idx), int'(done), 1);
    chk($sformatf("v%0d_busy_width", idx), busy_cnt, v.exp_busy + GAP);
    chk($sformatf("v%0d_addr_strobe", idx), wr_a, v.exp_pw);
    chk($sformatf("v%0d_wdata_strobe", idx), wr_d, v.rw ? v.exp_pw : 0);
    chk($sformatf("v%0d_rd_strobe", idx), rd_lo, v.rw ? 0 : v.exp_pw);
    chk($sformatf("v%0d_rd_valid_cnt", idx), rdv_cnt, v.rw ? 0 : 1);
    if (!v.rw) chk($sformatf("v%0d_rd_valid_idx", idx), rdv_idx, v.exp_rdv_idx);
    chk($sformatf("v%0d_pin_order", idx), viol, 0);
    chk($sformatf("v%0d_rdata", idx), int'(rdat_m), int'(v.exp_rdata));
  endtask

  vec_t vecs[6];

  initial begin
    int ph, w1, w2, lowgap, csgap, guard;
    bit seen_lo, hit;
    vecs[0] = '{1'b0, 1'b1, 8'h21, 8'h59, 8'h00, 8'h00, 17, 16, 4};
    vecs[1] = '{1'b0, 1'b0, 8'h22, 8'h00, 8'h07, 8'h07, 17, 16, 4};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h07, 17, 16, 4};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5, 17, 16, 4};
    vecs[4] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 8'h00, 8'h00,  7,  6, 1};
    vecs[5] = '{1'b1, 1'b0, 8'h7E, 8'h00, 8'h5A, 8'h5A,  7,  6, 1};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; rw = 1'b0; sel = 1'b0;
    addr = 8'h00; wdata = 8'h00; model_byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_rd_valid", int'(rdv_a), 0);
    chk("rst_rdata", int'(rdata_a), 0);
    chk("rst_strobes", int'({cs_n_a, rd_n_a, wr_n_a}), 7);
    chk("rst_ad_sel", int'(sel_a), 0);
    chk("rst_ad_oe", int'(dut_a.ad_oe_q), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // start held high across two writes: second begins the edge after busy falls.
    sel = 1'b0; rw = 1'b1; addr = 8'h10; wdata = 8'h11;
    @(negedge clk); start_a = 1'b1;
    ph = 0; w1 = 0; w2 = 0; lowgap = 0; csgap = 0; seen_lo = 1'b0; guard = 0;
    while (ph < 4 && guard < 200) begin
      @(negedge clk); guard++;
      case (ph)
        0: if (busy_a) begin ph = 1; w1 = 1; seen_lo = !cs_n_a; end
        1: begin
          if (busy_a) begin
            w1++;
            if (cs_n_a && seen_lo) csgap++;
            if (!cs_n_a) seen_lo = 1'b1;
          end else begin ph = 2; lowgap = 1; csgap++; end
        end
        2: begin
          if (!busy_a) begin lowgap++; csgap++; end
          else begin ph = 3; w2 = 1; end
        end
        default: begin
          if (busy_a) w2++;
          else begin ph = 4; start_a = 1'b0; end
        end
      endcase
    end
    start_a = 1'b0;
    chk("b2b_timeout", ph, 4);
    chk("b2b_busy1", w1, 17 + GAP);
    chk("b2b_busy_low", lowgap, 1);
    chk("b2b_busy2", w2, 17 + GAP);
    chk("b2b_cs_high_gap", csgap, 2 + GAP);
    repeat (2) @(negedge clk);
    chk("b2b_no_third", int'(busy_a), 0);

    // Reset in the data strobe of a write.
    rw = 1'b1; addr = 8'h33; wdata = 8'h44;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    hit = 1'b0; guard = 0;
    while (!hit && guard < 100) begin
      @(negedge clk); guard++;
      if (!wr_n_a && sel_a) hit = 1'b1;
    end
    chk("rst_mid_reach_dpw", int'(hit), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_cs_wr", int'({cs_n_a, wr_n_a}), 3);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_ad_oe", int'(dut_a.ad_oe_q), 0);
    @(negedge clk); reset = 1'b0;

    run_vec(vecs[0], 6);
    vecs[1].exp_rdata = 8'h07;
    run_vec(vecs[1], 7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
